// File: rtl/vec_lane_serializer.sv
// Vector-to-lane serializer: accepts a whole LANES x LANE_W vector and emits it one lane per beat.
// Optional build macro LANE_MASK_EN adds a per-lane emit mask (in_mask) that skips disabled lanes.
module vec_lane_serializer #(
  parameter int LANES  = 16,
  parameter int LANE_W = 32,
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LANES*LANE_W-1:0] in_vec,
  input  logic                    in_valid,
  output logic                    in_ready,
`ifdef LANE_MASK_EN
  input  logic [LANES-1:0]        in_mask,
`endif
  output logic [LANE_W-1:0]       out_data,
  output logic [IDX_W-1:0]        out_idx,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t            r_state;
  logic [LANE_W-1:0] r_vec [LANES];
  logic [LANES-1:0]  r_mask;
  logic [IDX_W-1:0]  r_idx;
  logic [LANE_W-1:0] r_data;
  logic              r_last;
  logic              r_in_ready;
  logic              r_out_valid;

  logic [LANES-1:0]  w_acc_mask;
  logic              w_acc_any;
  logic [IDX_W-1:0]  w_acc_idx;
  logic              w_acc_last;
  logic [LANE_W-1:0] w_acc_data;
  logic [IDX_W-1:0]  w_adv_idx;
  logic              w_adv_last;
  logic [LANE_W-1:0] w_adv_data;
  logic              w_accept;

  // Lowest set bit of m at position >= lo; 0 when there is none.
  function automatic logic [IDX_W-1:0] lowest_from(input logic [LANES-1:0] m, input int lo);
    logic [IDX_W-1:0] idx;
    logic             found;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      if (!found && k >= lo && m[k]) begin
        idx   = IDX_W'(k);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  function automatic logic any_from(input logic [LANES-1:0] m, input int lo);
    logic any;
    any = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      if (k >= lo && m[k]) any = 1'b1;
    end
    return any;
  endfunction

`ifdef LANE_MASK_EN
  assign w_acc_mask = in_mask;
`else
  assign w_acc_mask = {LANES{1'b1}};
`endif

  // First beat is taken straight from in_vec into the output register, so out_valid
  // rises one cycle after acceptance without any combinational in_vec->out_data path.
  always_comb begin
    w_accept   = in_valid && r_in_ready;
    w_acc_any  = |w_acc_mask;
    w_acc_idx  = lowest_from(w_acc_mask, 0);
    w_acc_last = !any_from(w_acc_mask, int'(w_acc_idx) + 1);
    w_acc_data = in_vec[int'(w_acc_idx)*LANE_W +: LANE_W];
    w_adv_idx  = lowest_from(r_mask, int'(r_idx) + 1);
    w_adv_last = !any_from(r_mask, int'(w_adv_idx) + 1);
    w_adv_data = r_vec[w_adv_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_mask      <= '0;
      r_idx       <= '0;
      r_data      <= '0;
      r_last      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      for (int k = 0; k < LANES; k++) r_vec[k] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            for (int k = 0; k < LANES; k++) r_vec[k] <= in_vec[k*LANE_W +: LANE_W];
            r_mask <= w_acc_mask;
            // An all-zero mask leaves nothing to emit, so stay ready for the next vector.
            if (w_acc_any) begin
              r_state     <= SEND;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_idx       <= w_acc_idx;
              r_last      <= w_acc_last;
              r_data      <= w_acc_data;
            end
          end
        end
        SEND: begin
          if (out_ready) begin
            if (r_last) begin
              r_state     <= IDLE;
              r_in_ready  <= 1'b1;
              r_out_valid <= 1'b0;
              r_idx       <= '0;
              r_last      <= 1'b0;
              r_data      <= '0;
            end else begin
              r_idx  <= w_adv_idx;
              r_last <= w_adv_last;
              r_data <= w_adv_data;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_data;
  assign out_idx   = r_idx;
  assign out_last  = r_last;

endmodule

// File: tb/tb_vec_lane_serializer.sv
// Self-checking bench for vec_lane_serializer: directed and random vectors against a queue model
// of the expected beats; a second LANES=4 / LANE_W=8 instance covers the small configuration.
module tb_vec_lane_serializer;

  localparam int LANES  = 16;
  localparam int LANE_W = 32;

  logic                    clk;
  logic                    rst;
  logic [LANES*LANE_W-1:0] in_vec;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES-1:0]        in_mask;
  logic [LANE_W-1:0]       out_data;
  logic [3:0]              out_idx;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_last;

  logic [31:0] s_in_vec;
  logic        s_in_valid;
  logic        s_in_ready;
  logic [3:0]  s_in_mask;
  logic [7:0]  s_out_data;
  logic [1:0]  s_out_idx;
  logic        s_out_valid;
  logic        s_out_ready;
  logic        s_out_last;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } beat_t;
  beat_t q[$];

  vec_lane_serializer dut (
    .clk(clk), .rst(rst), .in_vec(in_vec), .in_valid(in_valid), .in_ready(in_ready),
`ifdef LANE_MASK_EN
    .in_mask(in_mask),
`endif
    .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
  );

  vec_lane_serializer #(.LANES(4), .LANE_W(8)) dut_small (
    .clk(clk), .rst(rst), .in_vec(s_in_vec), .in_valid(s_in_valid), .in_ready(s_in_ready),
`ifdef LANE_MASK_EN
    .in_mask(s_in_mask),
`endif
    .out_data(s_out_data), .out_idx(s_out_idx), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_last(s_out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_data"}, 64'(out_data), 64'd0);
    check({tag, "_idx"}, 64'(out_idx), 64'd0);
    check({tag, "_last"}, 64'(out_last), 64'd0);
  endtask

  // mode 0: sink always ready; 1: random backpressure; 2: three stall cycles on lane 5.
  task automatic run_vector(input string name, input logic [LANES*LANE_W-1:0] vec,
                            input logic [LANES-1:0] mask, input int mode, input bit noise);
    int cyc;
    int stalls;
    int popped;
    int hold5;
    bit rdy;
    logic [LANES-1:0] m;
`ifdef LANE_MASK_EN
    m = mask;
`else
    m = '1;
`endif
    q.delete();
    for (int k = 0; k < LANES; k++)
      if (m[k]) q.push_back('{k, vec[k*LANE_W +: LANE_W]});
    @(negedge clk);
    check({name, "_accept_ready"}, 64'(in_ready), 64'd1);
    in_vec    = vec;
    in_mask   = mask;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    cyc = 0; stalls = 0; popped = 0; hold5 = 0;
    while (q.size() > 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (noise) begin
        in_valid = 1'($urandom);
        in_vec   = {LANES{$urandom()}};
        in_mask  = LANES'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      check({name, "_valid"}, 64'(out_valid), 64'd1);
      check({name, "_data"}, 64'(out_data), 64'(q[0].data));
      check({name, "_idx"}, 64'(out_idx), 64'(q[0].idx));
      check({name, "_last"}, 64'(out_last), 64'(q.size() == 1));
      check({name, "_busy"}, 64'(in_ready), 64'd0);
      if (mode == 1) rdy = ($urandom_range(0, 3) != 0);
      else if (mode == 2 && q[0].idx == 5 && hold5 < 3) begin rdy = 1'b0; hold5++; end
      else rdy = 1'b1;
      out_ready = rdy;
      if (rdy) begin void'(q.pop_front()); popped++; end
      else stalls++;
    end
    in_valid = 1'b0;
    check({name, "_drained"}, 64'(q.size()), 64'd0);
    check({name, "_cycles"}, 64'(cyc), 64'(popped + stalls));
    @(negedge clk);
    check_idle({name, "_after"});
    out_ready = 1'b0;
    $display("vector %s mask=%h beats=%0d stalls=%0d cycles=%0d", name, m, popped, stalls, cyc);
  endtask

  initial begin
    logic [LANES*LANE_W-1:0] v;
    logic [LANES*LANE_W-1:0] v2;
    logic [7:0] small_exp [4];
    small_exp = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

    rst = 1'b1; in_vec = '0; in_valid = 1'b0; in_mask = '0; out_ready = 1'b0;
    s_in_vec = '0; s_in_valid = 1'b0; s_in_mask = '0; s_out_ready = 1'b0;
    #1;
    check_idle("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < LANES; k++) v[k*LANE_W +: LANE_W] = 32'h1000_0000 + k;
    run_vector("ramp", v, '1, 0, 1'b0);
    run_vector("stall5", v, '1, 2, 1'b0);
    run_vector("noise", v, '1, 1, 1'b1);

`ifdef LANE_MASK_EN
    run_vector("mask8005", v, 16'h8005, 0, 1'b0);
    run_vector("mask0", v, 16'h0000, 0, 1'b0);
    run_vector("mask0001", v, 16'h0001, 1, 1'b0);
`endif

    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < LANES; k++) v2[k*LANE_W +: LANE_W] = $urandom;
      run_vector($sformatf("rand%0d", t), v2, LANES'($urandom), 1, t[0]);
    end

    // Reset while lane 7 is on the output: must drop to idle at once and never resume.
    @(negedge clk);
    in_vec = v; in_mask = '1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int b = 0; b < 7; b++) @(negedge clk);
    check("rst_pre_idx", 64'(out_idx), 64'd7);
    check("rst_pre_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b0;
    rst = 1'b1;
    #1;
    check_idle("rst_async");
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    for (int b = 0; b < 20; b++) begin
      @(negedge clk);
      check("rst_no_resume", 64'(out_valid), 64'd0);
    end
    out_ready = 1'b0;
    $display("vector reset_at_idx7 discarded");

    // Small configuration: 4 lanes of 8 bits.
    @(negedge clk);
    check("small_ready", 64'(s_in_ready), 64'd1);
    s_in_vec = 32'hDDCC_BBAA; s_in_mask = 4'hF; s_in_valid = 1'b1; s_out_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      s_in_valid = 1'b0;
      check("small_valid", 64'(s_out_valid), 64'd1);
      check("small_data", 64'(s_out_data), 64'(small_exp[b]));
      check("small_idx", 64'(s_out_idx), 64'(b));
      check("small_last", 64'(s_out_last), 64'(b == 3));
    end
    @(negedge clk);
    check("small_after_valid", 64'(s_out_valid), 64'd0);
    check("small_after_ready", 64'(s_in_ready), 64'd1);
    s_out_ready = 1'b0;
    $display("vector small DDCCBBAA beats=4");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vec_lane_serializer.md
VEC_LANE_SERIALIZER -- requirements
Module: vec_lane_serializer

Interface
REQ-001 SHALL have parameter LANES, default 16, the number of lanes per vector (any value 2..64).
REQ-002 SHALL have parameter LANE_W, default 32, the lane width in bits.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_vec  input  LANES*LANE_W  the packed vector; lane k occupies bits [k*LANE_W +: LANE_W].
REQ-006 SHALL have port in_valid  input  1  in_vec (and in_mask) are valid.
REQ-007 SHALL have port in_ready  output  1  the block accepts a vector this cycle.
REQ-008 SHALL have port in_mask  input  LANES  per-lane emit enable; present only with LANE_MASK_EN.
REQ-009 SHALL have port out_data  output  LANE_W  the current lane value.
REQ-010 SHALL have port out_idx  output  max(1,$clog2(LANES))  the lane index of out_data.
REQ-011 SHALL have port out_valid  output  1  out_data, out_idx and out_last are valid.
REQ-012 SHALL have port out_ready  input  1  the sink takes the lane this cycle.
REQ-013 SHALL have port out_last  output  1  the current lane is the final lane emitted for the vector.

Function
REQ-014 SHALL implement states IDLE and SEND; in_ready = 1 only in IDLE; out_valid = 1 only in SEND.
REQ-015 SHALL on in_valid && in_ready register the whole vector (and the mask), set the index to the first lane to emit, and enter SEND on the next edge.
REQ-016 SHALL assert out_valid on the cycle after acceptance (latency 1), with no combinational path from in_vec to out_data.
REQ-017 SHALL emit lanes in ascending index order, lane 0 first; out_data SHALL equal registered lane[out_idx].
REQ-018 SHALL, on out_valid && !out_ready, hold out_data, out_idx and out_last stable.
REQ-019 SHALL, on out_valid && out_ready with out_last = 0, advance to the next lane to emit on the next edge.
REQ-020 SHALL, on out_valid && out_ready with out_last = 1, return to IDLE; in_ready rises the following cycle (throughput: N emitted lanes + 1 cycle per vector).
REQ-021 SHALL ignore in_valid and in_vec while in SEND; the held vector is not disturbed.
REQ-022 SHALL keep out_data = 0, out_idx = 0 and out_last = 0 whenever out_valid = 0.

Reset
REQ-023 SHALL, while rst = 1, immediately force the state to IDLE, in_ready = 1, out_valid = 0, out_data = 0, out_idx = 0, out_last = 0, and clear the vector and mask registers.
REQ-024 SHALL, on a reset during SEND, discard the partial vector; no remaining lane is ever emitted.

Configuration
REQ-025 SHALL, with LANE_MASK_EN defined, provide in_mask; only lanes with mask bit 1 are emitted, skipping masked lanes with no idle cycles between emitted lanes; out_last marks the highest set bit.
REQ-026 SHALL, with LANE_MASK_EN defined and in_mask = 0 at acceptance, emit nothing and remain in IDLE with in_ready = 1.
REQ-027 SHALL, without LANE_MASK_EN, have no in_mask port and emit all LANES lanes; out_last = 1 when out_idx = LANES-1.

Verification
REQ-028 SHALL pass: defaults; in_vec lane k = 32'h1000_0000+k; out_ready=1 -> 16 beats on consecutive cycles, idx 0..15, data 0x10000000..0x1000000F, out_last only on idx 15, in_ready again on cycle 18.
REQ-029 SHALL pass: out_ready low for 3 cycles at idx 5 -> out_data=0x10000005 and idx 5 held for 3 cycles; idx 6 follows the cycle out_ready rises.
REQ-030 SHALL pass: new in_valid with a different vector during SEND -> ignored; all output beats match the first vector.
REQ-031 SHALL pass: LANE_MASK_EN, in_mask=16'h8005 -> three beats, idx 0, 2, 15, with out_last on idx 15; in_mask=0 -> no beats, in_ready stays 1.
REQ-032 SHALL pass: rst asserted at idx 7 -> out_valid=0 and in_ready=1 without a clock edge; after release, no lane from the old vector appears.
REQ-033 SHALL pass: LANES=4, LANE_W=8, in_vec=32'hDDCCBBAA -> beats AA, BB, CC, DD with idx 0..3 (2-bit).
